// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads a 16-word block, then streams W[0..NUM_ROUNDS-1]
// from a 16-word sliding window over a valid/ready handshake.
`timescale 1ns/1ps
module sha256_msg_sched #(
    parameter int unsigned NUM_ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [5:0]  out_idx,
    output logic        out_last,
    output logic        busy
);

    typedef enum logic {LOAD, EMIT} state_t;

    localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

    state_t      state, state_nx;
    logic [31:0] win [16];
    logic [4:0]  load_cnt;
    logic [5:0]  emit_cnt;
    logic        in_fire, out_fire, load_done, emit_done;
    logic [31:0] w_next;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == EMIT);
    // flush masks both handshakes so it wins over any transfer in the same cycle
    assign in_fire   = in_valid  & in_ready  & ~flush;
    assign out_fire  = out_valid & out_ready & ~flush;
    assign load_done = in_fire  && (load_cnt == 5'd15);
    assign emit_done = out_fire && (emit_cnt == LAST_IDX);

    assign out_word = win[0];
    assign out_idx  = emit_cnt;
    assign out_last = (state == EMIT) && (emit_cnt == LAST_IDX);
    assign busy     = (state != LOAD) || (load_cnt != 5'd0);

    // win[0] is W[t], so win[14], win[9], win[1] are W[t+14], W[t+9], W[t+1]
    assign w_next = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = LOAD;
        end else begin
            case (state)
                LOAD:    if (load_done) state_nx = EMIT;
                EMIT:    if (emit_done) state_nx = LOAD;
                default: state_nx = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
            load_cnt <= '0;
            emit_cnt <= '0;
        end else if (flush) begin
            load_cnt <= '0;
            emit_cnt <= '0;
        end else if (in_fire) begin
            win[load_cnt[3:0]] <= in_word;
            load_cnt <= load_done ? 5'd0 : load_cnt + 5'd1;
            if (load_done) begin
                emit_cnt <= '0;
            end
        end else if (out_fire) begin
            for (int unsigned i = 0; i < 15; i++) begin
                win[i] <= win[i+1];
            end
            win[15]  <= w_next;
            emit_cnt <= emit_done ? 6'd0 : emit_cnt + 6'd1;
        end
    end

endmodule
